// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader
// Brief    : Drains an attached FIFO (one-cycle read latency) into a
//            valid/ready stream via a 2-entry skid buffer. Counts delivered
//            words and records sticky read errors.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_en,
    output logic                  fifo_re,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [7:0]            rd_count,
    output logic                  err
);

    // The FIFO depth only describes the attached FIFO; reject nonsense values.
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("fifo_reader: FIFO_DEPTH must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_pend;
    logic [1:0]            r_buf_count;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [7:0]            r_rd_count;
    logic                  r_err;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;

    // A returning word is captured only when it answers a read and is error-free.
    assign w_pop  = out_valid & out_ready;
    assign w_push = r_pend & ~fifo_rd_err;
    // Occupancy next cycle if no new read is issued: buffered + in flight - leaving.
    assign w_occ  = {1'b0, r_buf_count} + {2'b00, r_pend} - {2'b00, w_pop};

    assign out_valid = (r_buf_count != 2'd0);
    assign out_data  = r_buf0;
    assign busy      = (r_state != ST_IDLE);
    assign rd_count  = r_rd_count;
    assign err       = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic plus FIFO enable/read request.
    always_comb begin
        w_next  = r_state;
        fifo_en = 1'b1;
        fifo_re = 1'b0;
        case (r_state)
            ST_IDLE: begin
                fifo_en = 1'b0;
                if (go) w_next = ST_RUN;
            end
            ST_RUN: begin
                fifo_re = ~fifo_empty & (w_occ < 3'd2);
                if (!go) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (go)                                      w_next = ST_RUN;
                else if (!r_pend && (r_buf_count == 2'd0))   w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Remember whether a read was issued last cycle (data arrives now).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pend <= 1'b0;
        else      r_pend <= fifo_re;
    end

    // Two-entry skid buffer; r_buf0 is always the oldest word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_count <= 2'd0;
            r_buf0      <= '0;
            r_buf1      <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_buf_count == 2'd0)      r_buf0 <= fifo_dout;
                    else if (r_buf_count == 2'd1) r_buf1 <= fifo_dout;
                    if (r_buf_count != 2'd2)      r_buf_count <= r_buf_count + 2'd1;
                end
                2'b01: begin
                    r_buf0      <= r_buf1;
                    r_buf_count <= r_buf_count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word goes behind whatever remains.
                    if (r_buf_count == 2'd1) begin
                        r_buf0 <= fifo_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Delivered-word counter (wraps naturally at 8 bits) and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop)       r_rd_count <= r_rd_count + 8'd1;
            if (fifo_rd_err) r_err      <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_reader
// Brief    : Self-checking bench for fifo_reader with a queue-based FIFO and
//            stream scoreboard, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          fifo_empty;
    logic          fifo_rd_err;
    logic [DW-1:0] fifo_dout;
    logic          fifo_en;
    logic          fifo_re;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [7:0]    rd_count;
    logic          err;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .fifo_empty (fifo_empty),
        .fifo_rd_err(fifo_rd_err),
        .fifo_dout  (fifo_dout),
        .fifo_en    (fifo_en),
        .fifo_re    (fifo_re),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .rd_count   (rd_count),
        .err        (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] fq[$];      // words held by the attached FIFO
    logic [DW-1:0] exp_q[$];   // words owed downstream, oldest first
    int            m_state;
    bit            m_pend;
    bit            m_inflight; // last exp_q entry is on fifo_dout, not yet buffered
    bit            m_err;
    logic [7:0]    m_cnt;
    bit            force_err;
    int            err_rate;
    int            re_total;
    int            pop_dut;
    bit            last_re;
    bit            re_hist[$];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input bit q[$], input int from);
        int n = 0;
        for (int i = from; i < q.size(); i++) n += int'(q[i]);
        return n;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        fq.delete();
        m_state    = M_IDLE;
        m_pend     = 1'b0;
        m_inflight = 1'b0;
        m_err      = 1'b0;
        m_cnt      = 8'd0;
        last_re    = 1'b0;
        force_err  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_fifo_re"},   fifo_re,   0);
        chk_val({tag, "_fifo_en"},   fifo_en,   0);
        chk_val({tag, "_busy"},      busy,      0);
        chk_val({tag, "_out_valid"}, out_valid, 0);
        chk_val({tag, "_out_data"},  out_data,  0);
        chk_val({tag, "_rd_count"},  rd_count,  0);
        chk_val({tag, "_err"},       err,       0);
    endtask

    // One clock cycle: entered at posedge+1 with inputs set; checks at negedge.
    task automatic cycle();
        int            buffered;
        bit            pop;
        bit            exp_re;
        bit            re;
        bit            inj;
        logic [DW-1:0] w;
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
        buffered = exp_q.size() - int'(m_inflight);
        pop      = out_ready && (buffered != 0);
        exp_re   = (m_state == M_RUN) && (fq.size() != 0) &&
                   (buffered + int'(m_pend) - int'(pop) < 2);
        chk_val("fifo_re",   fifo_re,   exp_re);
        chk_val("out_valid", out_valid, buffered != 0);
        if (buffered != 0) chk_val("out_data", out_data, exp_q[0]);
        chk_val("busy",      busy,      m_state != M_IDLE);
        chk_val("fifo_en",   fifo_en,   m_state != M_IDLE);
        chk_val("err",       err,       m_err);
        chk_val("rd_count",  rd_count,  m_cnt);
        chk_val("occupancy", exp_q.size() <= 2, 1);
        if (out_valid && out_ready) pop_dut++;
        re = fifo_re;
        re_hist.push_back(re);
        @(posedge clk);
        case (m_state)
            M_IDLE:  if (go) m_state = M_RUN;
            M_RUN:   if (!go) m_state = M_STOP;
            default: begin
                if (go) m_state = M_RUN;
                else if (!m_pend && buffered == 0) m_state = M_IDLE;
            end
        endcase
        if (fifo_rd_err) m_err = 1'b1;
        if (pop) begin
            void'(exp_q.pop_front());
            m_cnt++;
        end
        m_inflight = 1'b0;
        m_pend     = re;
        last_re    = re;
        if (re) re_total++;
        #1;
        if (re && fq.size() != 0) begin
            w   = fq.pop_front();
            inj = force_err || (err_rate != 0 && $urandom_range(1, err_rate) == 1);
            force_err   = 1'b0;
            fifo_dout   = w;
            fifo_rd_err = inj;
            if (!inj) begin
                exp_q.push_back(w);
                m_inflight = 1'b1;
            end
        end else begin
            fifo_dout   = DW'($urandom);   // idle-cycle garbage must be ignored
            fifo_rd_err = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    // Asynchronous reset applied between edges; entered at posedge+1.
    task automatic async_reset(input string tag);
        #3 rst = 1'b0;
        #1 chk_reset_outputs(tag);
        model_clear();
        fifo_rd_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        fifo_empty = 1'b1;
    endtask

    task automatic rand_phase(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(0, 19) == 0) go = ~go;
            out_ready = ($urandom_range(0, 9) < 7);
            if (fq.size() < DEPTH && $urandom_range(0, 1) == 1) fq.push_back(DW'($urandom));
            cycle();
        end
        go = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
    endtask

    initial begin
        int p0;
        int k;
        rst = 1'b0; go = 1'b0; out_ready = 1'b0;
        fifo_rd_err = 1'b0; fifo_dout = '0; fifo_empty = 1'b1;
        err_rate = 0; re_total = 0; pop_dut = 0;
        model_clear();
        #2 chk_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b1;

        // Three words streamed back-to-back
        fq.push_back(4'd3); fq.push_back(4'd5); fq.push_back(4'd7);
        go = 1'b1; out_ready = 1'b1;
        re_hist.delete(); p0 = pop_dut;
        repeat (8) cycle();
        chk_val("s1_reads", ones(re_hist, 0), 3);
        k = 0;
        for (int i = 0; i < re_hist.size(); i++) if (re_hist[i] && !re_hist[(i < 2) ? i : i - 2] && k == 0) k = i;
        chk_val("s1_pops", pop_dut - p0, 3);
        chk_val("s1_rd_count", rd_count, 3);
        begin
            int first = -1;
            int last  = -1;
            for (int i = 0; i < re_hist.size(); i++) if (re_hist[i]) begin
                if (first < 0) first = i;
                last = i;
            end
            chk_val("s1_read_span", last - first, 2);
        end
        go = 1'b0;
        repeat (4) cycle();
        chk_val("s1_idle", busy, 0);

        // Full FIFO with stalled downstream, then release
        for (int i = 0; i < 8; i++) fq.push_back(DW'(i));
        go = 1'b1; out_ready = 1'b0;
        re_hist.delete();
        repeat (10) cycle();
        chk_val("s2_reads_stalled", ones(re_hist, 0), 2);
        chk_val("s2_valid_held", out_valid, 1);
        chk_val("s2_data_held", out_data, 0);
        out_ready = 1'b1; p0 = pop_dut;
        repeat (20) cycle();
        chk_val("s2_delivered", pop_dut - p0, 8);
        go = 1'b0;
        repeat (4) cycle();

        // Empty FIFO with go asserted
        go = 1'b1; re_hist.delete();
        repeat (6) cycle();
        chk_val("s3_no_reads", ones(re_hist, 0), 0);
        chk_val("s3_out_valid", out_valid, 0);
        chk_val("s3_err", err, 0);
        chk_val("s3_busy", busy, 1);
        go = 1'b0;
        repeat (3) cycle();

        // Randomized traffic without read errors
        rand_phase(1500);

        // Go dropped the cycle after a read issue
        for (int i = 0; i < 4; i++) fq.push_back(DW'(i + 9));
        go = 1'b1; out_ready = 1'b1; p0 = pop_dut;
        k = 0;
        while (!last_re && k < 10) begin
            cycle();
            k++;
        end
        chk_val("s5_read_seen", last_re, 1);
        go = 1'b0; re_hist.delete();
        repeat (8) cycle();
        chk_val("s5_no_late_reads", ones(re_hist, 1), 0);
        chk_val("s5_delivered", pop_dut - p0 > 0, 1);
        chk_val("s5_busy", busy, 0);
        fq.delete();

        // Read error on a pending cycle
        fq.push_back(4'd9);
        force_err = 1'b1; go = 1'b1; out_ready = 1'b1; p0 = pop_dut;
        repeat (6) cycle();
        chk_val("s4_err_set", err, 1);
        chk_val("s4_no_spurious", pop_dut - p0, 0);
        go = 1'b0;
        repeat (5) cycle();
        chk_val("s4_err_sticky", err, 1);

        // Reset with two words buffered
        for (int i = 0; i < 4; i++) fq.push_back(DW'(i + 1));
        go = 1'b1; out_ready = 1'b0;
        repeat (6) cycle();
        chk_val("s6_buffered", out_valid, 1);
        async_reset("s6");
        go = 1'b0;
        repeat (2) cycle();

        // Randomized traffic with occasional read errors
        err_rate = 16;
        rand_phase(1500);
        err_rate = 0;

        // Counter wrap after 256 deliveries
        async_reset("s7");
        go = 1'b1; out_ready = 1'b1; p0 = pop_dut; k = 0;
        while (pop_dut - p0 < 256 && k < 1000) begin
            if (fq.size() < 4) fq.push_back(DW'($urandom));
            cycle();
            k++;
        end
        chk_val("s7_done", pop_dut - p0, 256);
        chk_val("s7_wrap", rd_count, 0);
        go = 1'b0;
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
